// File: rtl/instruction_fetch_unit.sv
// Pipeline front end: PC, word-loaded program memory, IF/ID register with MIPS delay-slot redirect.
// Optional IF_FETCH_COUNTER_EN macro adds a 32-bit counter of IF/ID loads on o_fetch_count.
module instruction_fetch_unit #(
   parameter int NB_INSTRUCTIONS = 32,
   parameter int NB_ADDRESS      = 32,
   parameter int NB_MEM_ADDR     = 8
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_clk_en,
   input  logic                       i_if_stall,
   input  logic                       i_if_halt,
   input  logic                       i_if_branch,
   input  logic [NB_ADDRESS-1:0]      i_if_branch_addr,
   input  logic                       i_load_en,
   input  logic [NB_INSTRUCTIONS-1:0] i_load_data,
   input  logic                       i_start,
   output logic [NB_INSTRUCTIONS-1:0] o_instruction,
   output logic [NB_ADDRESS-1:0]      o_pc,
   output logic [1:0]                 o_state,
   output logic                       o_load_full,
   output logic [31:0]                o_fetch_count
);

   localparam int DEPTH = 2 ** NB_MEM_ADDR;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'b00,
      ST_RUN    = 2'b01,
      ST_HALTED = 2'b10
   } state_t;

   state_t                     state_r;
   logic [NB_ADDRESS-1:0]      pc_r;
   logic [NB_ADDRESS-1:0]      pc_plus4_s;
   logic [NB_INSTRUCTIONS-1:0] mem_r [DEPTH];
   logic [NB_MEM_ADDR-1:0]     load_ptr_r;
   logic                       load_full_r;
   logic [NB_INSTRUCTIONS-1:0] instr_r;
   logic [NB_ADDRESS-1:0]      ifid_pc_r;
   logic [NB_INSTRUCTIONS-1:0] fetch_word_s;
   logic                       load_wr_s;
   logic                       fetch_s;

   // Next-PC, combinational memory read and enable qualifiers
   always_comb begin
      pc_plus4_s   = pc_r + NB_ADDRESS'(32'd4);
      fetch_word_s = mem_r[pc_r[NB_MEM_ADDR+1:2]];
      load_wr_s    = i_clk_en && (state_r == ST_LOAD) && i_load_en && !load_full_r;
      fetch_s      = i_clk_en && (state_r == ST_RUN) && !i_if_halt && !i_if_stall;
   end

   // Program memory write port; contents survive reset
   always_ff @(posedge i_clk) begin
      if (load_wr_s) begin
         mem_r[load_ptr_r] <= i_load_data;
      end
   end

   // FSM, load pointer, PC and IF/ID register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_r     <= ST_LOAD;
         pc_r        <= '0;
         instr_r     <= '0;
         ifid_pc_r   <= '0;
         load_ptr_r  <= '0;
         load_full_r <= 1'b0;
      end else if (i_clk_en) begin
         case (state_r)
            ST_LOAD: begin
               if (load_wr_s) begin
                  load_ptr_r <= load_ptr_r + NB_MEM_ADDR'(1'b1);
                  if (load_ptr_r == {NB_MEM_ADDR{1'b1}}) begin
                     load_full_r <= 1'b1;
                  end
               end
               if (i_start) begin
                  state_r <= ST_RUN;
               end
            end
            ST_RUN: begin
               // Halt wins over stall, stall over branch; the branch cycle still fetches the delay slot
               if (i_if_halt) begin
                  state_r <= ST_HALTED;
               end else if (fetch_s) begin
                  instr_r   <= fetch_word_s;
                  ifid_pc_r <= pc_plus4_s;
                  pc_r      <= i_if_branch ? i_if_branch_addr : pc_plus4_s;
               end
            end
            ST_HALTED: begin
               state_r <= ST_HALTED;
            end
            default: begin
               state_r <= ST_LOAD;
            end
         endcase
      end
   end

`ifdef IF_FETCH_COUNTER_EN
   logic [31:0] fetch_count_r;

   // Counts every cycle that loads IF/ID, wrapping naturally
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         fetch_count_r <= 32'd0;
      end else if (fetch_s) begin
         fetch_count_r <= fetch_count_r + 32'd1;
      end
   end

   assign o_fetch_count = fetch_count_r;
`else
   assign o_fetch_count = 32'd0;
`endif

   assign o_instruction = instr_r;
   assign o_pc          = ifid_pc_r;
   assign o_state       = state_r;
   assign o_load_full   = load_full_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed scenarios plus randomized traffic
// against a behavioural model; expected counter value follows IF_FETCH_COUNTER_EN.
module tb_instruction_fetch_unit;

   localparam int MA    = 5;
   localparam int DEPTH = 2 ** MA;

   logic        i_clk = 1'b0;
   logic        i_reset, i_clk_en, i_if_stall, i_if_halt, i_if_branch;
   logic [31:0] i_if_branch_addr;
   logic        i_load_en;
   logic [31:0] i_load_data;
   logic        i_start;
   logic [31:0] o_instruction, o_pc, o_fetch_count;
   logic [1:0]  o_state;
   logic        o_load_full;

   instruction_fetch_unit #(.NB_INSTRUCTIONS(32), .NB_ADDRESS(32), .NB_MEM_ADDR(MA)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_clk_en(i_clk_en), .i_if_stall(i_if_stall),
      .i_if_halt(i_if_halt), .i_if_branch(i_if_branch), .i_if_branch_addr(i_if_branch_addr),
      .i_load_en(i_load_en), .i_load_data(i_load_data), .i_start(i_start),
      .o_instruction(o_instruction), .o_pc(o_pc), .o_state(o_state),
      .o_load_full(o_load_full), .o_fetch_count(o_fetch_count)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [31:0] ins;
      logic [31:0] pc;
      logic [1:0]  st;
      logic        full;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Behavioural model: program array, PC, IF/ID pair, phase, load pointer
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_pc, m_ins, m_opc, m_cnt;
   logic [1:0]  m_state;
   int          m_ptr;
   logic        m_full;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_cnt();
`ifdef IF_FETCH_COUNTER_EN
      return m_cnt;
`else
      return 32'd0;
`endif
   endfunction

   task automatic m_step(input bit rst, en, stall, halt, br, input logic [31:0] baddr,
                         input bit ld, input logic [31:0] ldata, input bit start);
      if (rst) begin
         m_pc = 0; m_ins = 0; m_opc = 0; m_cnt = 0; m_state = 2'd0; m_ptr = 0; m_full = 0;
      end else if (en) begin
         if (m_state == 2'd0) begin
            if (ld && !m_full) begin
               m_mem[m_ptr] = ldata;
               m_ptr++;
               if (m_ptr == DEPTH) begin
                  m_full = 1'b1;
                  m_ptr  = 0;
               end
            end
            if (start) m_state = 2'd1;
         end else if (m_state == 2'd1) begin
            if (halt) m_state = 2'd2;
            else if (!stall) begin
               m_ins = m_mem[(m_pc >> 2) % DEPTH];
               m_opc = m_pc + 32'd4;
               m_pc  = br ? baddr : m_pc + 32'd4;
               m_cnt = m_cnt + 32'd1;
            end
         end
      end
   endtask

   task automatic push_exp();
      exp_t e;
      e.ins = m_ins; e.pc = m_opc; e.st = m_state; e.full = m_full; e.cnt = exp_cnt();
      sb.push_back(e);
   endtask

   // One clock: drive at the falling edge, predict the post-rising-edge state
   task automatic cyc(input bit rst, en, stall, halt, br, input logic [31:0] baddr,
                      input bit ld, input logic [31:0] ldata, input bit start);
      i_reset = rst; i_clk_en = en; i_if_stall = stall; i_if_halt = halt; i_if_branch = br;
      i_if_branch_addr = baddr; i_load_en = ld; i_load_data = ldata; i_start = start;
      m_step(rst, en, stall, halt, br, baddr, ld, ldata, start);
      push_exp();
      @(negedge i_clk);
   endtask

   task automatic idle();
      cyc(0, 1, 0, 0, 0, 32'd0, 0, 32'd0, 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ins"}, o_instruction, 32'd0);
      chk({tag, "_pc"}, o_pc, 32'd0);
      chk({tag, "_state"}, {30'd0, o_state}, 32'd0);
      chk({tag, "_full"}, {31'd0, o_load_full}, 32'd0);
      chk({tag, "_cnt"}, o_fetch_count, 32'd0);
   endtask

   // Monitor: every registered update is compared against the queued prediction
   initial begin
      exp_t e;
      forever begin
         @(posedge i_clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("mon_ins", o_instruction, e.ins);
            chk("mon_pc", o_pc, e.pc);
            chk("mon_state", {30'd0, o_state}, {30'd0, e.st});
            chk("mon_full", {31'd0, o_load_full}, {31'd0, e.full});
            chk("mon_cnt", o_fetch_count, e.cnt);
         end
      end
   end

   initial begin
      logic [31:0] prog [3];
      logic [31:0] a;
      bit          found;
      prog[0] = 32'h20010005; prog[1] = 32'h00000000; prog[2] = 32'hFC000000;
      i_reset = 1; i_clk_en = 0; i_if_stall = 0; i_if_halt = 0; i_if_branch = 0;
      i_if_branch_addr = 0; i_load_en = 0; i_load_data = 0; i_start = 0;
      m_step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge i_clk);
      chk_reset_vals("rst");

      // Load three words, run until HALT is in IF/ID, then halt
      for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 0, 0, 1, prog[k], 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 1);
      found = 0;
      for (int k = 0; k < 10 && !found; k++) begin
         if (m_ins == 32'hFC000000) found = 1;
         else idle();
      end
      chk("halt_word_reached", o_instruction, 32'hFC000000);
      cyc(0, 1, 0, 1, 0, 0, 0, 0, 0);
      chk("halted_state", {30'd0, o_state}, 32'd2);
      chk("halted_pc", o_pc, 32'd12);
      for (int k = 0; k < 4; k++)
         cyc(0, 1, k[0], k[1], 1, 32'h40, 1, $urandom(), 1);

      // Full load with one overflow write, then branch/stall interaction at PC 0x10
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k <= DEPTH; k++) cyc(0, 1, 0, 0, 0, 0, 1, $urandom(), 0);
      chk("load_full", {31'd0, o_load_full}, 32'd1);
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 1);
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         if (m_pc == 32'h10) found = 1;
         else idle();
      end
      cyc(0, 1, 1, 0, 1, 32'h40, 0, 0, 0);
      cyc(0, 1, 1, 0, 1, 32'h40, 0, 0, 0);
      chk("stall_hold_pc", o_pc, 32'h10);
      cyc(0, 1, 0, 0, 1, 32'h40, 0, 0, 0);
      chk("delay_slot_pc", o_pc, 32'h14);
      idle();
      chk("branch_target_pc", o_pc, 32'h44);
      idle();

      // Asynchronous reset between edges during RUN; memory retained
      i_reset = 0; i_clk_en = 1; i_if_stall = 0; i_if_halt = 0; i_if_branch = 0;
      i_load_en = 0; i_start = 0;
      #2 i_reset = 1;
      #1 chk_reset_vals("async_rst");
      #1 i_reset = 0;
      m_step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      m_step(0, 1, 0, 0, 0, 0, 0, 0, 0);
      push_exp();
      @(negedge i_clk);

      // Restart without reload: 10 fetches with 2 stalls interleaved
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 12; k++) cyc(0, 1, (k == 3 || k == 7), 0, 0, 0, 0, 0, 0);
`ifdef IF_FETCH_COUNTER_EN
      chk("fetch_count_10", o_fetch_count, 32'd10);
`else
      chk("fetch_count_off", o_fetch_count, 32'd0);
`endif

      // Randomized traffic across all inputs
      for (int k = 0; k < 1500; k++) begin
         case ($urandom_range(0, 3))
            0: a = $urandom();
            1: a = 32'hFFFFFFFC;
            2: a = {25'd0, 5'($urandom()), 2'b00};
            default: a = {24'd0, 8'($urandom())};
         endcase
         cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 4) != 0),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 79) == 0),
             ($urandom_range(0, 5) == 0), a, $urandom_range(0, 1), $urandom(),
             ($urandom_range(0, 7) == 0));
      end
      idle();
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
